axi_lite_master: RTL and testbench

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_pkg.sv | 16 +
 rtl/axi_lite_if.sv | 34 +++
 rtl/axi_lite_master.sv | 132 +++++++++++++
 tb/tb_axi_lite_master.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI-Lite response codes and master FSM states shared by master and memory slave
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP,
    DRAIN
  } state_e;
endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI-Lite channel bundle with master and slave views
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst_n
);
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    b_valid;
  logic                    b_ready;
  logic [1:0]              b_resp;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  modport master (
    output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
  modport slave (
    input  clk, rst_n, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI-Lite master turning cmd requests into AW/W/B or AR/R transactions
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  axi_lite_if.master              m_axi
);
  localparam int CW      = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  localparam bit HAS_TMO = TIMEOUT != 0;
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic                    aw_pend_q, aw_pend_d;
  logic                    w_pend_q, w_pend_d;
  logic                    tmo_q, tmo_d;
  logic                    slv_hit;
  logic                    tmo_hit;
  assign slv_hit = wr_q ? m_axi.b_valid : m_axi.r_valid;
  assign tmo_hit = HAS_TMO && cnt_q == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      tmo_q     <= tmo_d;
    end
  end
  // A timed-out response always leaves a late B/R behind, so tmo_q doubles as the drain-pending flag
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    tmo_d     = tmo_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        addr_d    = cmd_addr;
        wdata_d   = cmd_wdata;
        wstrb_d   = cmd_wstrb;
        wr_d      = cmd_write;
        aw_pend_d = cmd_write;
        w_pend_d  = cmd_write;
        state_d   = cmd_write ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        aw_pend_d = aw_pend_q && !m_axi.aw_ready;
        w_pend_d  = w_pend_q && !m_axi.w_ready;
        if (!aw_pend_d && !w_pend_d) begin
          state_d = WR_RESP;
          cnt_d   = '0;
        end
      end
      RD_REQ: if (m_axi.ar_ready) begin
        state_d = RD_RESP;
        cnt_d   = '0;
      end
      WR_RESP, RD_RESP: begin
        if (slv_hit || tmo_hit) begin
          state_d = RSP;
          rdata_d = slv_hit && !wr_q ? m_axi.r_data : '0;
          resp_d  = !slv_hit ? RESP_SLVERR : wr_q ? m_axi.b_resp : m_axi.r_resp;
          tmo_d   = !slv_hit;
        end else begin
          cnt_d = HAS_TMO ? cnt_q + 1'b1 : '0;
        end
      end
      RSP: if (rsp_ready) state_d = tmo_q ? DRAIN : IDLE;
      DRAIN: if (slv_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign cmd_ready      = state_q == IDLE;
  assign rsp_valid      = state_q == RSP;
  assign rsp_rdata      = rdata_q;
  assign rsp_resp       = resp_q;
  assign rsp_timeout    = tmo_q;
  assign m_axi.aw_valid = state_q == WR_REQ && aw_pend_q;
  assign m_axi.aw_addr  = addr_q;
  assign m_axi.w_valid  = state_q == WR_REQ && w_pend_q;
  assign m_axi.w_data   = wdata_q;
  assign m_axi.w_strb   = wstrb_q;
  assign m_axi.b_ready  = state_q == WR_RESP || (state_q == DRAIN && wr_q);
  assign m_axi.ar_valid = state_q == RD_REQ;
  assign m_axi.ar_addr  = addr_q;
  assign m_axi.r_ready  = state_q == RD_RESP || (state_q == DRAIN && !wr_q);
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: scoreboard bench driving the master against a behavioral memory slave
module tb_axi_lite_master;
  import axi_lite_pkg::*;
  localparam int TMO = 8;
  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  int checks = 0, errors = 0, issued = 0, acc_cyc = 0;
  int cyc_n = 0, rsp_hs = 0, awst_n = 0, wv_n = 0, bhs_n = 0, bw_n = 0;
  int aw_stall = 0, r_delay = 0;
  bit ar_hold = 1'b0, b_mute = 1'b0;
  exp_t sb[$];
  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi (.clk(clk), .rst_n(!rst));
  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .m_axi(axi)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) rsp_hs <= rsp_hs + 1;
    if (axi.aw_valid && !axi.aw_ready) awst_n <= awst_n + 1;
    if (axi.w_valid) wv_n <= wv_n + 1;
    if (axi.b_valid && axi.b_ready) bhs_n <= bhs_n + 1;
    if (axi.b_ready && !axi.b_valid) bw_n <= bw_n + 1;
  end
  // memory slave: 16 words, B two cycles after AW+W, R after r_delay cycles
  logic [31:0] mem [16];
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] awa, wd, rd;
  logic [3:0]  ws;
  int          aw_cnt, r_cnt;
  assign axi.aw_ready = aw_cnt >= aw_stall;
  assign axi.w_ready  = 1'b1;
  assign axi.b_valid  = b_pend && !b_mute;
  assign axi.b_resp   = RESP_OKAY;
  assign axi.ar_ready = !ar_hold;
  assign axi.r_valid  = r_pend && r_cnt >= r_delay;
  assign axi.r_data   = rd;
  assign axi.r_resp   = RESP_OKAY;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      awa <= '0; wd <= '0; rd <= '0; ws <= '0; aw_cnt <= 0; r_cnt <= 0;
    end else begin
      if (axi.aw_valid && axi.aw_ready) begin
        awa <= axi.aw_addr; aw_got <= 1'b1; aw_cnt <= 0;
      end else if (axi.aw_valid) aw_cnt <= aw_cnt + 1;
      if (axi.w_valid && axi.w_ready) begin
        wd <= axi.w_data; ws <= axi.w_strb; w_got <= 1'b1;
      end
      if (aw_got && w_got && !b_pend) begin
        for (int i = 0; i < 4; i++) if (ws[i]) mem[awa[5:2]][8*i +: 8] <= wd[8*i +: 8];
        b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (axi.b_valid && axi.b_ready) b_pend <= 1'b0;
      if (r_pend) r_cnt <= r_cnt + 1;
      if (axi.ar_valid && axi.ar_ready) begin
        rd <= mem[axi.ar_addr[5:2]]; r_pend <= 1'b1; r_cnt <= 0;
      end
      if (axi.r_valid && axi.r_ready) r_pend <= 1'b0;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic exp_t mk(input logic [31:0] r, input logic [1:0] c, input logic t);
    mk = '{rdata: r, resp: c, tmo: t};
  endfunction
  task automatic present(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin step(1); n++; end
    if (!cmd_ready) check("accept_wait", 32'(cmd_ready), 32'd1);
    acc_cyc = cyc_n;
    step(1);
    cmd_valid = 1'b0;
  endtask
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input exp_t e);
    sb.push_back(e);
    issued++;
    present(w, a, d, s);
  endtask
  task automatic get_rsp(input string tag, output int lat);
    exp_t e;
    int n = 0;
    while (!rsp_valid && n < 100) begin step(1); n++; end
    lat = cyc_n - acc_cyc;
    if (!rsp_valid) check({tag, "_no_rsp"}, 32'(rsp_valid), 32'd1);
    else if (sb.size() == 0) check({tag, "_sb_underflow"}, 32'(sb.size()), 32'd1);
    else begin
      e = sb.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_resp"}, 32'(rsp_resp), 32'(e.resp));
      check({tag, "_tmo"}, 32'(rsp_timeout), 32'(e.tmo));
      step(1);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1);
  end
  initial begin
    int lat, b0, a0, w0, h0;
    bit ok;
    step(3);
    rst = 1'b0;
    step(1);
    check("rst_flags", 32'({cmd_ready, rsp_valid, rsp_timeout, axi.aw_valid, axi.w_valid,
                            axi.ar_valid, axi.b_ready, axi.r_ready, rsp_resp}), 32'h200);
    check("rst_rdata", rsp_rdata, 32'h0);
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, mk(32'h0, RESP_OKAY, 1'b0));
    get_rsp("wr10", lat);
    issue(1'b0, 32'h10, 32'h0, 4'h0, mk(32'hDEADBEEF, RESP_OKAY, 1'b0));
    get_rsp("rd10", lat);
    check("rd_latency", 32'(lat), 32'd3);
    issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, mk(32'h0, RESP_OKAY, 1'b0));
    get_rsp("wr20_full", lat);
    issue(1'b1, 32'h20, 32'h11223344, 4'h3, mk(32'h0, RESP_OKAY, 1'b0));
    get_rsp("wr20_strb", lat);
    issue(1'b0, 32'h20, 32'h0, 4'h0, mk(32'hFFFF3344, RESP_OKAY, 1'b0));
    get_rsp("rd20", lat);
    aw_stall = 5; a0 = awst_n; w0 = wv_n; b0 = bhs_n; h0 = rsp_hs;
    issue(1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, mk(32'h0, RESP_OKAY, 1'b0));
    get_rsp("aw_stall", lat);
    aw_stall = 0;
    step(2);
    check("aw_stall_cycles", 32'(awst_n - a0), 32'd5);
    check("w_valid_cycles", 32'(wv_n - w0), 32'd1);
    check("aw_stall_b_count", 32'(bhs_n - b0), 32'd1);
    check("aw_stall_rsp_count", 32'(rsp_hs - h0), 32'd1);
    b_mute = 1'b1; b0 = bw_n; h0 = rsp_hs; a0 = bhs_n;
    issue(1'b1, 32'h14, 32'h0BADF00D, 4'hF, mk(32'h0, RESP_SLVERR, 1'b1));
    get_rsp("wr_tmo", lat);
    check("wr_tmo_wait", 32'(bw_n - b0), 32'(TMO));
    check("drain_bready", 32'(axi.b_ready), 32'd1);
    check("drain_cmd_ready", 32'(cmd_ready), 32'd0);
    step(3);
    b_mute = 1'b0;
    step(2);
    check("drain_done", 32'({cmd_ready, axi.b_ready, rsp_valid}), 32'b100);
    check("drain_late_b", 32'(bhs_n - a0), 32'd1);
    check("drain_rsp_count", 32'(rsp_hs - h0), 32'd1);
    issue(1'b0, 32'h14, 32'h0, 4'h0, mk(32'h0BADF00D, RESP_OKAY, 1'b0));
    get_rsp("rd14_after_drain", lat);
    r_delay = TMO - 1;
    issue(1'b0, 32'h10, 32'h0, 4'h0, mk(32'hDEADBEEF, RESP_OKAY, 1'b0));
    get_rsp("rd_edge_tmo", lat);
    check("edge_no_drain", 32'({cmd_ready, axi.r_ready}), 32'b10);
    r_delay = TMO;
    issue(1'b0, 32'h20, 32'h0, 4'h0, mk(32'h0, RESP_SLVERR, 1'b1));
    get_rsp("rd_tmo", lat);
    check("rd_drain_rready", 32'(axi.r_ready), 32'd1);
    step(1);
    check("rd_drain_done", 32'({cmd_ready, axi.r_ready}), 32'b10);
    r_delay = 0;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h20, 32'h0, 4'h0, mk(32'hFFFF3344, RESP_OKAY, 1'b0));
    for (int n = 0; n < 100 && !rsp_valid; n++) step(1);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ok &= rsp_valid && rsp_rdata == 32'hFFFF3344 && !cmd_ready;
      step(1);
    end
    check("rsp_hold", 32'(ok), 32'd1);
    rsp_ready = 1'b1;
    get_rsp("rsp_hold_rd", lat);
    ar_hold = 1'b1;
    present(1'b0, 32'h24, 32'h0, 4'h0);
    check("ar_pending", 32'(axi.ar_valid), 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_async_arvalid", 32'(axi.ar_valid), 32'd0);
    step(2);
    ar_hold = 1'b0;
    rst = 1'b0;
    h0 = rsp_hs;
    step(1);
    check("post_rst_flags", 32'({cmd_ready, rsp_valid}), 32'b10);
    step(5);
    check("aborted_no_rsp", 32'(rsp_hs - h0), 32'd0);
    issue(1'b0, 32'h20, 32'h0, 4'h0, mk(32'hFFFF3344, RESP_OKAY, 1'b0));
    get_rsp("post_rst_rd", lat);
    step(2);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("rsp_total", 32'(rsp_hs), 32'(issued));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
